// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Defining REG_FILE_R0_ZERO_EN hard-wires entry 0 to zero.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Same-address write collision: port 0 (ALU writeback) wins when set.
  localparam bit WR_PRIO_PORT0 = 1'b1;

`ifdef REG_FILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// DEPTH:1 combinational read mux with two-port write bypass and busy masking.
// Honours REG_FILE_R0_ZERO_EN through reg_file_pkg::R0_ZERO.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] entries,
  input  logic [DEPTH-1:0]            busy,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        wr0_en,
  input  logic [AW-1:0]               wr0_addr,
  input  logic [WIDTH-1:0]            wr0_data,
  input  logic                        wr1_en,
  input  logic [AW-1:0]               wr1_addr,
  input  logic [WIDTH-1:0]            wr1_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_busy
);

  logic rd_live;
  logic hit0;
  logic hit1;

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    rd_live = (int'(rd_addr) < DEPTH) && !(R0_ZERO && (rd_addr == '0));
    hit0    = rd_live && wr0_en && (wr0_addr == rd_addr);
    hit1    = rd_live && wr1_en && (wr1_addr == rd_addr);
    rd_data = '0;
    if (!rd_live)                            rd_data = '0;
    else if (hit0 && (WR_PRIO_PORT0 || !hit1)) rd_data = wr0_data;
    else if (hit1)                           rd_data = wr1_data;
    else if (hit0)                           rd_data = wr0_data;
    else                                     rd_data = entries[rd_addr];
    // A same-cycle reservation stays invisible until the next cycle.
    rd_busy = rd_live && busy[rd_addr] && !hit0 && !hit1;
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2R/2W register file with write-to-read bypass and a busy scoreboard.
// Defining REG_FILE_R0_ZERO_EN makes entry 0 a hard-wired zero.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_busy,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_busy,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_addr,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [AW:0]      busy_cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q,  mem_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [AW:0]                 busy_cnt_q, busy_cnt_d;

  always_comb begin
    logic live, w0, w1, rv;
    int   n_rise, n_fall;
    mem_d  = mem_q;
    busy_d = busy_q;
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < DEPTH; i++) begin
      // Out-of-range addresses never equal any i, so they decode to nothing.
      live = !(R0_ZERO && (i == 0));
      w0   = live && wr0_en && (wr0_addr == AW'(i));
      w1   = live && wr1_en && (wr1_addr == AW'(i));
      rv   = live && rsv_en && (rsv_addr == AW'(i));
      if (w0 && w1) mem_d[i] = WR_PRIO_PORT0 ? wr0_data : wr1_data;
      else if (w0)  mem_d[i] = wr0_data;
      else if (w1)  mem_d[i] = wr1_data;
      // A new reservation outranks a same-cycle writeback to that entry.
      if (rv)            busy_d[i] = 1'b1;
      else if (w0 || w1) busy_d[i] = 1'b0;
      if (busy_d[i] && !busy_q[i]) n_rise = n_rise + 1;
      if (!busy_d[i] && busy_q[i]) n_fall = n_fall + 1;
    end
    busy_cnt_d = busy_cnt_q + (AW+1)'(n_rise) - (AW+1)'(n_fall);
  end

  // NOTE: the storage array is reset too, because entries must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  reg_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd0 (
    .entries (mem_q),
    .busy    (busy_q),
    .rd_addr (rd0_addr),
    .wr0_en  (wr0_en),
    .wr0_addr(wr0_addr),
    .wr0_data(wr0_data),
    .wr1_en  (wr1_en),
    .wr1_addr(wr1_addr),
    .wr1_data(wr1_data),
    .rd_data (rd0_data),
    .rd_busy (rd0_busy)
  );

  reg_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd1 (
    .entries (mem_q),
    .busy    (busy_q),
    .rd_addr (rd1_addr),
    .wr0_en  (wr0_en),
    .wr0_addr(wr0_addr),
    .wr0_data(wr0_data),
    .wr1_en  (wr1_en),
    .wr1_addr(wr1_addr),
    .wr1_data(wr1_data),
    .rd_data (rd1_data),
    .rd_busy (rd1_busy)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a default 16x8 instance and a DEPTH=6 instance.
// Expectations follow REG_FILE_R0_ZERO_EN when the bench is built with it.
module tb_reg_file_param;

`ifdef REG_FILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic [2:0]  rd0_addr, rd1_addr, wr0_addr, wr1_addr, rsv_addr;
  logic [15:0] rd0_data, rd1_data, wr0_data, wr1_data;
  logic        rd0_busy, rd1_busy, wr0_en, wr1_en, rsv_en;
  logic [3:0]  busy_cnt;

  logic [2:0]  s_rd0_addr, s_rd1_addr, s_wr0_addr, s_wr1_addr, s_rsv_addr;
  logic [15:0] s_rd0_data, s_rd1_data, s_wr0_data, s_wr1_data;
  logic        s_rd0_busy, s_rd1_busy, s_wr0_en, s_wr1_en, s_rsv_en;
  logic [3:0]  s_busy_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_busy(rd0_busy),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_busy(rd1_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(s_rd0_addr), .rd0_data(s_rd0_data), .rd0_busy(s_rd0_busy),
    .rd1_addr(s_rd1_addr), .rd1_data(s_rd1_data), .rd1_busy(s_rd1_busy),
    .wr0_en(s_wr0_en), .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data),
    .wr1_en(s_wr1_en), .wr1_addr(s_wr1_addr), .wr1_data(s_wr1_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .busy_cnt(s_busy_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    s_wr0_en = 1'b0; s_wr1_en = 1'b0; s_rsv_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd0_addr = '0; rd1_addr = '0; wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
    s_rd0_addr = '0; s_rd1_addr = '0; s_wr0_addr = '0; s_wr1_addr = '0; s_rsv_addr = '0;
    s_wr0_data = '0; s_wr1_data = '0;
    idle();
    #12 rst_n = 1'b1;
    #1;

    // Reset state on every address.
    check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(7 - a);
      #1;
      check($sformatf("rst_rd0_data[%0d]", a), 32'(rd0_data), 32'h0);
      check($sformatf("rst_rd0_busy[%0d]", a), 32'(rd0_busy), 32'd0);
      check($sformatf("rst_rd1_data[%0d]", 7 - a), 32'(rd1_data), 32'h0);
    end

    // Plain write, read back next cycle.
    tick();
    wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'hBEEF; rd0_addr = 3'd3;
    tick();
    idle(); #1;
    check("wr0_r3_stored", 32'(rd0_data), 32'hBEEF);

    // Same-address double write: port 0 wins in bypass and in storage.
    wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 16'h1111;
    wr1_en = 1'b1; wr1_addr = 3'd5; wr1_data = 16'h2222; rd1_addr = 3'd5;
    #1;
    check("bypass_prio_rd1", 32'(rd1_data), 32'h1111);
    tick();
    idle(); #1;
    check("dual_wr_stored", 32'(rd1_data), 32'h1111);

    // Port 1 bypass alone.
    wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 16'h00AA; rd0_addr = 3'd2;
    #1;
    check("bypass_wr1_rd0", 32'(rd0_data), 32'h00AA);
    tick();
    idle();

    // Reservation is visible only from the next cycle.
    rsv_en = 1'b1; rsv_addr = 3'd4; rd0_addr = 3'd4; rd1_addr = 3'd4;
    #1;
    check("rsv_r4_same_cycle", 32'(rd0_busy), 32'd0);
    tick();
    idle(); #1;
    check("rsv_r4_busy_rd0", 32'(rd0_busy), 32'd1);
    check("rsv_r4_busy_rd1", 32'(rd1_busy), 32'd1);
    check("rsv_r4_cnt", 32'(busy_cnt), 32'd1);

    // Writeback clears the busy view immediately and the bit on the edge.
    wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 16'h0042;
    #1;
    check("wb_r4_busy_masked", 32'(rd0_busy), 32'd0);
    check("wb_r4_data_bypass", 32'(rd0_data), 32'h0042);
    tick();
    idle(); #1;
    check("wb_r4_cnt", 32'(busy_cnt), 32'd0);

    // Reservation outranks a same-cycle write to the same entry.
    rsv_en = 1'b1; rsv_addr = 3'd6; wr0_en = 1'b1; wr0_addr = 3'd6; wr0_data = 16'h0606;
    rd0_addr = 3'd6;
    tick();
    idle(); #1;
    check("rsv_wr_r6_busy", 32'(rd0_busy), 32'd1);
    check("rsv_wr_r6_cnt", 32'(busy_cnt), 32'd1);
    check("rsv_wr_r6_data", 32'(rd0_data), 32'h0606);
    wr1_en = 1'b1; wr1_addr = 3'd6; wr1_data = 16'h6000;
    tick();
    idle(); #1;
    check("r6_release_cnt", 32'(busy_cnt), 32'd0);

    // Entry 0: hard-wired zero only when the feature is built in.
    wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 16'hABCD;
    rsv_en = 1'b1; rsv_addr = 3'd0; rd0_addr = 3'd0;
    #1;
    check("r0_same_data", 32'(rd0_data), R0Z ? 32'h0 : 32'hABCD);
    check("r0_same_busy", 32'(rd0_busy), 32'd0);
    tick();
    idle(); #1;
    check("r0_next_data", 32'(rd0_data), R0Z ? 32'h0 : 32'hABCD);
    check("r0_next_busy", 32'(rd0_busy), R0Z ? 32'd0 : 32'd1);
    check("r0_next_cnt", 32'(busy_cnt), R0Z ? 32'd0 : 32'd1);

    // Fill the scoreboard, then re-reserve an already-busy entry.
    for (int a = 0; a < 8; a++) begin
      rsv_en = 1'b1; rsv_addr = 3'(a);
      tick();
    end
    idle(); #1;
    check("fill_cnt", 32'(busy_cnt), R0Z ? 32'd7 : 32'd8);
    rsv_en = 1'b1; rsv_addr = 3'd1;
    tick();
    idle(); #1;
    check("rerserve_r1_cnt", 32'(busy_cnt), R0Z ? 32'd7 : 32'd8);

    // Asynchronous reset between edges clears everything at once.
    rd0_addr = 3'd1; rd1_addr = 3'd3;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(busy_cnt), 32'd0);
    check("async_rst_busy", 32'(rd0_busy), 32'd0);
    check("async_rst_data", 32'(rd1_data), 32'h0);
    #1 rst_n = 1'b1;

    // Two entries released by both write ports in one cycle.
    tick();
    rsv_en = 1'b1; rsv_addr = 3'd1;
    tick();
    rsv_addr = 3'd2;
    tick();
    idle(); #1;
    check("two_busy_cnt", 32'(busy_cnt), 32'd2);
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h0001;
    wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 16'h0002;
    tick();
    idle(); #1;
    check("dual_release_cnt", 32'(busy_cnt), 32'd0);
    rd0_addr = 3'd1; rd1_addr = 3'd2;
    #1;
    check("dual_release_rd0", 32'(rd0_data), 32'h0001);
    check("dual_release_rd1", 32'(rd1_data), 32'h0002);

    // DEPTH=6 instance: addresses 6 and 7 are out of range.
    s_wr0_en = 1'b1; s_wr0_addr = 3'd7; s_wr0_data = 16'hFFFF;
    s_wr1_en = 1'b1; s_wr1_addr = 3'd5; s_wr1_data = 16'h5555;
    s_rsv_en = 1'b1; s_rsv_addr = 3'd6;
    s_rd0_addr = 3'd7; s_rd1_addr = 3'd6;
    #1;
    check("d6_oor_no_bypass", 32'(s_rd0_data), 32'h0);
    tick();
    idle(); #1;
    check("d6_oor_data", 32'(s_rd0_data), 32'h0);
    check("d6_oor_busy7", 32'(s_rd0_busy), 32'd0);
    check("d6_oor_busy6", 32'(s_rd1_busy), 32'd0);
    check("d6_oor_cnt", 32'(s_busy_cnt), 32'd0);
    s_rd1_addr = 3'd5;
    #1;
    check("d6_r5_stored", 32'(s_rd1_data), 32'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the fixed 8-entry, 16-bit register file.
- Generalised in width and depth; the two write ports are ALU writeback and load writeback.
- Two read ports with write-to-read bypass.
- Per-entry scoreboard (busy bits) with a reserve port and a busy counter. Decode uses it to stall on pending destinations.

Parameters:
- WIDTH, 16, data width of each entry.
- DEPTH, 8, number of entries (≥2; need not be a power of 2).
- AW, derived localparam $clog2(DEPTH), address width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd0_addr  in  AW  read port 0 address.
- rd0_data  out  WIDTH  read port 0 data, bypassed.
- rd0_busy  out  1  scoreboard bit of rd0_addr, bypassed.
- rd1_addr  in  AW  read port 1 address.
- rd1_data  out  WIDTH  read port 1 data.
- rd1_busy  out  1  scoreboard bit of rd1_addr.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  AW  write port 0 address.
- wr0_data  in  WIDTH  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback).
- wr1_addr  in  AW  write port 1 address.
- wr1_data  in  WIDTH  write port 1 data.
- rsv_en  in  1  reserve: mark rsv_addr pending.
- rsv_addr  in  AW  entry to reserve.
- busy_cnt  out  AW+1  number of entries currently busy.

Behaviour:
- Reset (async assert, sync-release assumed upstream): all entries 0, all busy bits 0, busy_cnt 0. Asserting reset mid-operation drops all pending reservations immediately.
- Reads are combinational with zero latency. Priority for rdN_data:
  - wr0_en && wr0_addr==rdN_addr → wr0_data;
  - else wr1_en && wr1_addr==rdN_addr → wr1_data;
  - else stored entry.
- Writes commit on the rising clk edge.
  - Both ports enabled to the same address: wr0 is stored, wr1 is discarded.
  - Different addresses: both are stored.
- Busy bit, next state per entry, in priority order:
  - rsv_en hit → 1 (a new reservation outranks a same-cycle write);
  - else any write hit → 0;
  - else hold.
- rdN_busy = busy[rdN_addr] & ~(write hit on rdN_addr this cycle) & ~(rsv hit on rdN_addr this cycle is NOT considered). A reservation only becomes visible in the next cycle.
- busy_cnt is a registered counter updated each edge: +1 on 0→1 transitions, −1 on 1→0 transitions.
  - Reserving an already-busy entry does not change the count.
  - Writing an idle entry does not change the count.
  - busy_cnt always equals the popcount of the busy bits; it never exceeds DEPTH and never goes below 0.
- Out-of-range address (≥DEPTH, non-power-of-2 DEPTH only):
  - writes and reservations are ignored;
  - reads return 0 with busy 0;
  - no bypass match.

Optional Feature:
- Macro: REG_FILE_R0_ZERO_EN.
- Defined: entry 0 is hard-wired zero.
  - Writes and reservations to address 0 are ignored.
  - Reads of address 0 return 0 with busy 0, with no bypass.
  - busy bit 0 is never counted.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Shared package reg_file_pkg holds:
  - default WIDTH/DEPTH constants;
  - a clog2-based address-width helper function;
  - write-port priority constants (WR_PRIO_PORT0).
- Natural sub-module: reg_read_port. It is a parametrised DEPTH:1 read mux with two-port bypass and busy masking, instantiated once per read port. It replaces the fixed 8:1 mux.

Test Plan (WIDTH=16, DEPTH=8 unless stated):
- Reset then read all 8 addresses → data 0x0000, busy 0, busy_cnt 0. Then write r3=0xBEEF via wr0 → next cycle rd0_addr=3 gives 0xBEEF.
- Bypass priority:
  - wr0 (r5=0x1111) and wr1 (r5=0x2222) in the same cycle with rd1_addr=5 → rd1_data=0x1111 that cycle; stored 0x1111 afterwards.
  - wr1-only write r2=0x00AA with rd0_addr=2 → rd0_data=0x00AA combinationally.
- Scoreboard:
  - rsv r4 → next cycle rd0_busy=1 and busy_cnt=1.
  - wr1 r4=0x0042 → rd0_busy=0 in the same cycle; next cycle busy_cnt=0.
  - rsv r6 together with wr0 r6 in the same cycle → r6 stays busy and busy_cnt=1.
- Counter saturation: reserve r0..r7 over 8 cycles → busy_cnt reaches 8. Re-reserving r1 keeps 8. Assert rst_n low mid-sequence → busy_cnt=0 and busy bits clear immediately, without waiting for a clock.
- DEPTH=6 build: write addr 7=0xFFFF and reserve addr 6 → read of addr 7 returns 0 with busy 0, and busy_cnt stays 0.
- With REG_FILE_R0_ZERO_EN: wr0 r0=0xABCD plus rsv r0 → rd0_data=0 and rd0_busy=0 that cycle and the next, busy_cnt=0. Without the macro → r0 reads 0xABCD and busy_cnt=1.
